// File: rtl/line_fill_buffer_pkg.sv
// Shared definitions for the line fill buffer: AXI burst constants and FSM encoding.
package line_fill_buffer_pkg;

  localparam int         LFB_WORD_W     = 32;
  localparam logic [7:0] AXI_LEN_LINE   = 8'd7;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    LFB_IDLE = 2'd0,
    LFB_ADDR = 2'd1,
    LFB_DATA = 2'd2,
    LFB_DONE = 2'd3
  } lfb_state_t;

  // Word slot for a beat of a critical-word-first WRAP burst.
  function automatic logic [2:0] wrap_slot(input logic [2:0] ci, input logic [2:0] beat);
    return ci + beat;
  endfunction

endpackage

// File: rtl/line_word_store.sv
// Line storage: one register per word, single indexed write port, flat line view.
module line_word_store
  import line_fill_buffer_pkg::*;
#(
  parameter int LINE_WORDS = 8
) (
  input  logic                               Clk,
  input  logic                               Rst,
  input  logic                               i_we,
  input  logic [$clog2(LINE_WORDS)-1:0]      i_idx,
  input  logic [LFB_WORD_W-1:0]              i_data,
  output logic [LINE_WORDS*LFB_WORD_W-1:0]   o_line
);

  logic [LFB_WORD_W-1:0] r_words [LINE_WORDS];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int k = 0; k < LINE_WORDS; k++) r_words[k] <= '0;
    end else if (i_we) begin
      r_words[i_idx] <= i_data;
    end
  end

  always_comb begin
    o_line = '0;
    for (int k = 0; k < LINE_WORDS; k++) o_line[k*LFB_WORD_W +: LFB_WORD_W] = r_words[k];
  end

endmodule

// File: rtl/line_fill_buffer.sv
// Fetches one cache line critical-word-first over an AXI4 WRAP read burst.
module line_fill_buffer
  import line_fill_buffer_pkg::*;
#(
  parameter int LINE_WORDS  = 8,
  parameter int OFFSET_BITS = 5
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         En,
  input  logic [31:0]                  WordAddress,
  output logic [31:0]                  LineAddress,
  output logic                         FirstWord,
  output logic [31:0]                  CritData,
  output logic                         Completed,
  output logic [LINE_WORDS*32-1:0]     LineData,
  output logic                         Error,
  output logic [31:0]                  ARADDR,
  output logic [7:0]                   ARLEN,
  output logic [2:0]                   ARSIZE,
  output logic [1:0]                   ARBURST,
  output logic                         ARVALID,
  input  logic                         ARREADY,
  input  logic [31:0]                  RDATA,
  input  logic [1:0]                   RRESP,
  input  logic                         RLAST,
  input  logic                         RVALID,
  output logic                         RREADY
);

  localparam int          IW        = $clog2(LINE_WORDS);
  localparam logic [IW-1:0] LAST_BEAT = IW'(LINE_WORDS - 1);
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

  lfb_state_t    r_state, w_state_nxt;
  logic          w_start, w_beat, w_last;
  logic          r_armed, r_dropped;
  logic [IW-1:0] r_ci, r_beat, w_widx;
  logic [31:0]   r_line_addr, r_araddr, r_crit;
  logic          r_arvalid, r_rready, r_first, r_completed, r_error;

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= LFB_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_beat      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      LFB_IDLE: if (En && r_armed) begin
        w_start     = 1'b1;
        w_state_nxt = LFB_ADDR;
      end
      LFB_ADDR: if (r_arvalid && ARREADY) w_state_nxt = LFB_DATA;
      LFB_DATA: if (r_rready && RVALID) begin
        w_beat = 1'b1;
        // The beat counter, not RLAST, ends the burst.
        if (r_beat == LAST_BEAT) begin
          w_last      = 1'b1;
          w_state_nxt = LFB_DONE;
        end
      end
      LFB_DONE: if (!En || r_dropped) w_state_nxt = LFB_IDLE;
      default:  w_state_nxt = LFB_IDLE;
    endcase
  end

  assign w_widx = wrap_slot(r_ci, r_beat);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_armed     <= 1'b1;
      r_dropped   <= 1'b0;
      r_ci        <= '0;
      r_beat      <= '0;
      r_line_addr <= '0;
      r_araddr    <= '0;
      r_crit      <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_first     <= 1'b0;
      r_completed <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_arvalid   <= (w_state_nxt == LFB_ADDR);
      r_rready    <= (w_state_nxt == LFB_DATA);
      r_completed <= (w_state_nxt == LFB_DONE);
      r_first     <= w_beat && (r_beat == '0);
      if (w_start) begin
        r_line_addr <= WordAddress & LINE_MASK;
        r_araddr    <= WordAddress & ~32'h3;
        r_ci        <= WordAddress[IW+1:2];
        r_beat      <= '0;
        r_error     <= 1'b0;
        r_dropped   <= 1'b0;
        r_armed     <= 1'b0;
      end else if (!En) begin
        // Re-arm only on a low seen outside a fill; a mid-fill low just ends DONE early.
        if (r_state == LFB_IDLE || r_state == LFB_DONE) r_armed <= 1'b1;
        if (r_state == LFB_ADDR || r_state == LFB_DATA) r_dropped <= 1'b1;
      end
      if (w_beat) begin
        r_beat <= r_beat + 1'b1;
        if (r_beat == '0) r_crit <= RDATA;
        if (RRESP != AXI_RESP_OKAY || RLAST != w_last) r_error <= 1'b1;
      end
    end
  end

  line_word_store #(.LINE_WORDS(LINE_WORDS)) u_store (
    .Clk    (Clk),
    .Rst    (Rst),
    .i_we   (w_beat),
    .i_idx  (w_widx),
    .i_data (RDATA),
    .o_line (LineData)
  );

  assign LineAddress = r_line_addr;
  assign FirstWord   = r_first;
  assign CritData    = r_crit;
  assign Completed   = r_completed;
  assign Error       = r_error;
  assign ARADDR      = r_araddr;
  assign ARLEN       = AXI_LEN_LINE;
  assign ARSIZE      = AXI_SIZE_WORD;
  assign ARBURST     = AXI_BURST_WRAP;
  assign ARVALID     = r_arvalid;
  assign RREADY      = r_rready;

endmodule
